// File: rtl/sr_pkg.sv
// Shared types for the SR flag arbiter: FSM state encoding and {S,R} op codes.
package sr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_RST   = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_HOLD2 = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr, scanning upward with wrap.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id
);

    // Scan from the far end back toward ptr so the closest requester is the last one written.
    always_comb begin : scan
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin shared access to a bank of clocked SR flag cells; one command per IDLE/APPLY/ACK pass.
module sr_flag_arbiter
    import sr_pkg::*;
#(
    parameter int  NREQ   = 4,
    parameter int  NFLAGS = 8,
    localparam int AW     = $clog2(NFLAGS),
    localparam int PW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [AW*NREQ-1:0]   req_addr,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic                 busy,
    output logic [NFLAGS-1:0]    flags,
    output logic [NFLAGS-1:0]    flags_n,
    output state_t               dbg_state
);

    // Handshake: a requester holds req with op/addr stable until it sees its one-cycle ack;
    // op/addr are captured only when granted in IDLE, so later changes or a dropped req are ignored.

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   win_q;
    logic [1:0]      op_q;
    logic [AW-1:0]   addr_q;
    logic            gnt_valid;
    logic [PW-1:0]   gnt_id;
    logic            addr_bad;
    logic [NFLAGS-1:0] cell_en;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign addr_bad  = (int'(addr_q) >= NFLAGS);
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            op_q    <= OP_HOLD;
            addr_q  <= '0;
            ack     <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack <= '0;
                    err <= 1'b0;
                    if (gnt_valid) begin
                        win_q   <= gnt_id;
                        op_q    <= req_op[2*int'(gnt_id) +: 2];
                        addr_q  <= req_addr[AW*int'(gnt_id) +: AW];
                        busy    <= 1'b1;
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    ack     <= NREQ'(1) << win_q;
                    err     <= addr_bad;
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    ack     <= '0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    ptr_q   <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
                    state_q <= ST_IDLE;
                end
                default: begin
                    ack     <= '0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // An out-of-range address matches no cell, so the bank is untouched on err.
    for (genvar i = 0; i < NFLAGS; i++) begin : g_cell
        assign cell_en[i] = (state_q == ST_APPLY) && (addr_q == AW'(i));

        always_ff @(posedge clk) begin
            if (reset) begin
                flags[i] <= 1'b0;
            end else if (cell_en[i]) begin
                case (op_q)
                    OP_SET:  flags[i] <= 1'b1;
                    OP_RST:  flags[i] <= 1'b0;
                    default: flags[i] <= flags[i];
                endcase
            end
        end
    end

    assign flags_n = ~flags;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: a vector table of single commands plus hand-written multi-cycle cases.
module tb_sr_flag_arbiter;
    import sr_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // dut_a: 8 flags; dut_b: 6 flags so address 7 is out of range
    logic [3:0]  req_a, req_b;
    logic [7:0]  op_a, op_b;
    logic [11:0] addr_a, addr_b;
    logic [3:0]  ack_a, ack_b;
    logic        err_a, err_b, busy_a, busy_b;
    logic [7:0]  flags_a, flags_n_a;
    logic [5:0]  flags_b, flags_n_b;
    state_t      st_a, st_b;

    sr_flag_arbiter #(.NREQ(4), .NFLAGS(8)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .req_op(op_a), .req_addr(addr_a),
        .ack(ack_a), .err(err_a), .busy(busy_a), .flags(flags_a), .flags_n(flags_n_a),
        .dbg_state(st_a)
    );

    sr_flag_arbiter #(.NREQ(4), .NFLAGS(6)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .req_op(op_b), .req_addr(addr_b),
        .ack(ack_b), .err(err_b), .busy(busy_b), .flags(flags_b), .flags_n(flags_n_b),
        .dbg_state(st_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle invariants on both instances
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("flags_n_a", 32'(flags_n_a ^ flags_a), 32'hFF);
            check("flags_n_b", 32'(flags_n_b ^ flags_b), 32'h3F);
            check("ack_a_onehot", 32'($countones(ack_a) <= 1), 32'd1);
            check("ack_b_onehot", 32'($countones(ack_b) <= 1), 32'd1);
            check("ack_a_outside_ack", 32'((ack_a != 4'd0) && (st_a != ST_ACK)), 32'd0);
            check("ack_b_outside_ack", 32'((ack_b != 4'd0) && (st_b != ST_ACK)), 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_a = '0;
        req_b = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Starts at a negedge with dut_a idle; expects ack exactly two negedges later.
    task automatic cmd_a(input int id, input logic [1:0] op, input logic [2:0] addr,
                         input logic [7:0] exp_flags, input string tag);
        int lat;
        logic [3:0] a;
        req_a = '0;
        req_a[id] = 1'b1;
        op_a[2*id +: 2] = op;
        addr_a[3*id +: 3] = addr;
        lat = 0;
        a = '0;
        while (a == 4'd0 && lat < 8) begin
            @(negedge clk);
            lat++;
            a = ack_a;
        end
        check({tag, "_ack"}, 32'(a), 32'(4'b0001 << id));
        check({tag, "_latency"}, lat, 2);
        check({tag, "_err"}, 32'(err_a), 32'd0);
        check({tag, "_flags"}, 32'(flags_a), 32'(exp_flags));
        req_a = '0;
        @(negedge clk);
        check({tag, "_idle"}, 32'(busy_a), 32'd0);
    endtask

    task automatic cmd_b(input int id, input logic [1:0] op, input logic [2:0] addr,
                         input logic exp_err, input logic [5:0] exp_flags, input string tag);
        int lat;
        logic [3:0] a;
        req_b = '0;
        req_b[id] = 1'b1;
        op_b[2*id +: 2] = op;
        addr_b[3*id +: 3] = addr;
        lat = 0;
        a = '0;
        while (a == 4'd0 && lat < 8) begin
            @(negedge clk);
            lat++;
            a = ack_b;
        end
        check({tag, "_ack"}, 32'(a), 32'(4'b0001 << id));
        check({tag, "_latency"}, lat, 2);
        check({tag, "_err"}, 32'(err_b), 32'(exp_err));
        check({tag, "_flags"}, 32'(flags_b), 32'(exp_flags));
        req_b = '0;
        @(negedge clk);
        check({tag, "_idle"}, 32'(busy_b), 32'd0);
    endtask

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [2:0] addr;
        logic [7:0] exp_flags;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int got, cyc, last;

        vecs[0] = '{0, 2'b10, 3'd3, 8'h08};
        vecs[1] = '{0, 2'b01, 3'd3, 8'h00};
        vecs[2] = '{0, 2'b11, 3'd5, 8'h00};
        vecs[3] = '{0, 2'b00, 3'd5, 8'h00};
        vecs[4] = '{2, 2'b10, 3'd7, 8'h80};
        vecs[5] = '{3, 2'b10, 3'd0, 8'h81};
        vecs[6] = '{1, 2'b01, 3'd7, 8'h01};
        vecs[7] = '{3, 2'b11, 3'd0, 8'h01};

        reset = 1'b1;
        req_a = '0; op_a = '0; addr_a = '0;
        req_b = '0; op_b = '0; addr_b = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_flags", 32'(flags_a), 32'd0);
        check("rst_flags_n", 32'(flags_n_a), 32'hFF);
        check("rst_state", 32'(st_a), 32'(ST_IDLE));
        check("rst_flags_b", 32'(flags_b), 32'd0);
        check("rst_flags_n_b", 32'(flags_n_b), 32'h3F);
        reset = 1'b0;

        // Single-requester command table
        for (int i = 0; i < 8; i++) begin
            cmd_a(vecs[i].id, vecs[i].op, vecs[i].addr, vecs[i].exp_flags, $sformatf("vec%0d", i));
        end

        // All four requesters held: grants rotate 0,1,2,3,0 with one ack every 3 cycles
        do_reset();
        req_a = 4'hF;
        for (int i = 0; i < 4; i++) begin
            op_a[2*i +: 2]   = 2'b10;
            addr_a[3*i +: 3] = 3'(i);
        end
        got = 0; cyc = 0; last = 0;
        while (got < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ack_a != 4'd0) begin
                check("rr_order", 32'(ack_a), 32'(4'b0001 << (got % 4)));
                if (got > 0) check("rr_spacing", cyc - last, 3);
                last = cyc;
                got++;
                if (got == 4) check("rr_flags_4", 32'(flags_a), 32'h0F);
                if (got == 5) req_a = '0;
            end
        end
        check("rr_ack_count", got, 5);
        check("rr_flags", 32'(flags_a), 32'h0F);
        @(negedge clk);
        check("rr_idle", 32'(busy_a), 32'd0);

        // Out-of-range address on the 6-flag instance
        cmd_b(2, 2'b10, 3'd7, 1'b1, 6'h00, "oob");
        cmd_b(2, 2'b10, 3'd5, 1'b0, 6'h20, "oob_next");
        cmd_b(0, 2'b10, 3'd0, 1'b0, 6'h21, "oob_next2");

        // Reset while in APPLY aborts the command
        do_reset();
        req_a = 4'b0010;
        op_a[3:2] = 2'b10;
        addr_a[5:3] = 3'd4;
        @(negedge clk);
        check("abort_in_apply", 32'(st_a), 32'(ST_APPLY));
        reset = 1'b1;
        req_a = '0;
        @(negedge clk);
        check("abort_state", 32'(st_a), 32'(ST_IDLE));
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_ack", 32'(ack_a), 32'd0);
        check("abort_flags", 32'(flags_a), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_late_ack", 32'(ack_a), 32'd0);
        @(negedge clk);
        check("abort_no_late_ack2", 32'(ack_a), 32'd0);
        check("abort_flags_after", 32'(flags_a), 32'd0);

        // Req dropped (and op/addr changed) right after capture: original command still completes
        req_a = 4'b0010;
        op_a[3:2] = 2'b10;
        addr_a[5:3] = 3'd6;
        @(negedge clk);
        req_a = '0;
        op_a[3:2] = 2'b01;
        addr_a[5:3] = 3'd1;
        @(negedge clk);
        check("drop_ack", 32'(ack_a), 32'b0010);
        check("drop_flags", 32'(flags_a), 32'h40);
        @(negedge clk);
        check("drop_idle", 32'(busy_a), 32'd0);

        // Two requesters on cell 2: req1 sets first, req3 resets last
        do_reset();
        req_a = 4'b1010;
        op_a[3:2] = 2'b10;
        addr_a[5:3] = 3'd2;
        op_a[7:6] = 2'b01;
        addr_a[11:9] = 3'd2;
        got = 0; cyc = 0;
        while (got < 2 && cyc < 16) begin
            @(negedge clk);
            cyc++;
            if (ack_a != 4'd0) begin
                if (got == 0) begin
                    check("same_cell_first", 32'(ack_a), 32'b0010);
                    check("same_cell_flags1", 32'(flags_a), 32'h04);
                    req_a[1] = 1'b0;
                end else begin
                    check("same_cell_second", 32'(ack_a), 32'b1000);
                    check("same_cell_flags2", 32'(flags_a), 32'h00);
                    req_a[3] = 1'b0;
                end
                got++;
            end
        end
        check("same_cell_ack_count", got, 2);
        @(negedge clk);
        check("same_cell_idle", 32'(busy_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
